// File: rtl/param_sync_fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Status struct, counter width helper and threshold/parameter checks.
package param_sync_fifo_pkg;

    localparam int STAT_CNT_W = 16;

    typedef struct packed {
        logic                  full;
        logic                  empty;
        logic                  alm_full;
        logic                  alm_empty;
        logic [STAT_CNT_W-1:0] count;
    } fifo_status_t;

    // Fill counter needs one bit more than the pointers to represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit thresholds_ok(input int depth, input int af_thresh, input int ae_thresh);
        return (ae_thresh < af_thresh) && (af_thresh <= depth);
    endfunction

    function automatic fifo_status_t calc_status(input int unsigned count,
                                                 input int unsigned depth,
                                                 input int unsigned af_thresh,
                                                 input int unsigned ae_thresh);
        fifo_status_t s;
        s.full      = (count == depth);
        s.empty     = (count == 0);
        s.alm_full  = (count >= af_thresh);
        s.alm_empty = (count <= ae_thresh);
        s.count     = STAT_CNT_W'(count);
        return s;
    endfunction

endpackage

// File: rtl/param_sync_fifo_ram.sv
// Simple dual-port storage: one write port, read port either asynchronous
// (first-word-fall-through) or registered with a read enable.
module fifo_ram #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_async_rd
            logic unused_rd_ctrl;
            assign unused_rd_ctrl = rst ^ rd_en;
            assign rd_data = mem[rd_addr];
        end else begin : g_reg_rd
            // Only the output register is reset; the array keeps whatever it held.
            logic [DATA_W-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[rd_addr];
                end
            end
            assign rd_data = rd_q;
        end
    endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with thresholds, flush, sticky error flags
// and selectable standard or first-word-fall-through read.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wren,
    input  logic [DATA_W-1:0]             i_wrdata,
    input  logic                          i_rden,
    input  logic                          i_flush,
    input  logic                          i_clr_err,
    output logic [DATA_W-1:0]             o_rddata,
    output logic                          o_rdvalid,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_alm_full,
    output logic                          o_alm_empty,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_overflow,
    output logic                          o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $fatal(1, "param_sync_fifo: DEPTH must be a power of 2 and >= 2");
        end
        if (!thresholds_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_thresh
            $fatal(1, "param_sync_fifo: need AE_THRESH < AF_THRESH <= DEPTH");
        end
    endgenerate

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              rdvalid_q;
    logic              ovf_q;
    logic              unf_q;
    fifo_status_t      status;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              unf_set;
    logic [DATA_W-1:0] ram_rd;
    logic              unused_status_bits;

    assign status = calc_status(32'(count), DEPTH, AF_THRESH, AE_THRESH);
    assign unused_status_bits = ^status.count;

    // Acceptance looks only at registered status, so full+rd+wr rejects the write.
    assign wr_acc  = i_wren && !status.full  && !i_flush;
    assign rd_acc  = i_rden && !status.empty && !i_flush;
    assign ovf_set = i_wren &&  status.full  && !i_flush;
    assign unf_set = i_rden &&  status.empty && !i_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rdvalid_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                rdvalid_q <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
                if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
                case ({wr_acc, rd_acc})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                rdvalid_q <= rd_acc;
            end
            if (ovf_set)        ovf_q <= 1'b1;
            else if (i_clr_err) ovf_q <= 1'b0;
            if (unf_set)        unf_q <= 1'b1;
            else if (i_clr_err) unf_q <= 1'b0;
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (i_wrdata),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            logic unused_rdvalid;
            assign unused_rdvalid = rdvalid_q;
            // Array is not reset, so mask the head word while nothing is stored.
            assign o_rddata  = status.empty ? '0 : ram_rd;
            assign o_rdvalid = !status.empty;
        end else begin : g_std
            assign o_rddata  = ram_rd;
            assign o_rdvalid = rdvalid_q;
        end
    endgenerate

    assign o_full      = status.full;
    assign o_empty     = status.empty;
    assign o_alm_full  = status.alm_full;
    assign o_alm_empty = status.alm_empty;
    assign o_count     = count;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;

endmodule
